// File: rtl/msrv32_wr_en_ctrl.sv
// Registered multi-channel write-enable controller for the msrv32 writeback stage.
// Gates writes on flush, a post-flush squash window, stall and address-zero suppression.
module msrv32_wr_en_ctrl #(
  parameter int                NUM_CH        = 2,
  parameter int                ADDR_W        = 12,
  parameter int                DATA_W        = 32,
  parameter int                SQUASH_CYCLES = 2,
  parameter logic [NUM_CH-1:0] ZERO_SUPPRESS = NUM_CH'(2'b01),
  parameter int                CNT_W         = 8
) (
  input  logic                     ms_riscv32_mp_clk_in,
  input  logic                     ms_riscv32_mp_rst_in,
  input  logic                     flush_in,
  input  logic                     stall_in,
  input  logic [NUM_CH-1:0]        wr_en_req_in,
  input  logic [NUM_CH*ADDR_W-1:0] wr_addr_in,
  input  logic [NUM_CH*DATA_W-1:0] wr_data_in,
  input  logic                     kill_cnt_clr_in,
  output logic [NUM_CH-1:0]        wr_en_out,
  output logic [NUM_CH*ADDR_W-1:0] wr_addr_out,
  output logic [NUM_CH*DATA_W-1:0] wr_data_out,
  output logic                     squash_active_out,
  output logic [CNT_W-1:0]         kill_cnt_out
);

  typedef enum logic {RUN, SQUASH} state_t;

  localparam logic [3:0]       SQ_LOAD = 4'(SQUASH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t                     state_q, state_d;
  logic [3:0]                 sq_cnt_q, sq_cnt_d;
  logic [NUM_CH-1:0]          wr_en_q, wr_en_d;
  logic [NUM_CH*ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_CH*DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]           kill_cnt_q, kill_cnt_d;
  logic [NUM_CH-1:0]          zsup;
  logic [NUM_CH-1:0]          kill_vec;
  logic [3:0]                 kill_pop;
  logic [CNT_W:0]             kill_sum;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_zsup
    assign zsup[gi] = ZERO_SUPPRESS[gi] & (wr_addr_in[gi*ADDR_W +: ADDR_W] == '0);
  end

  always_comb begin
    state_d  = state_q;
    sq_cnt_d = sq_cnt_q;
    wr_en_d  = '0;
    addr_d   = addr_q;
    data_d   = data_q;
    kill_vec = '0;
    if (flush_in) begin
      addr_d   = wr_addr_in;
      data_d   = wr_data_in;
      sq_cnt_d = SQ_LOAD;
      state_d  = (SQ_LOAD != 4'd0) ? SQUASH : RUN;
      kill_vec = wr_en_req_in;
    end else if (stall_in) begin
      // Blocked requests are replayed by upstream, so nothing is killed here.
      kill_vec = '0;
    end else if (state_q == SQUASH) begin
      addr_d   = wr_addr_in;
      data_d   = wr_data_in;
      sq_cnt_d = sq_cnt_q - 4'd1;
      if (sq_cnt_q == 4'd1) state_d = RUN;
      kill_vec = wr_en_req_in;
    end else begin
      addr_d   = wr_addr_in;
      data_d   = wr_data_in;
      wr_en_d  = wr_en_req_in & ~zsup;
      kill_vec = wr_en_req_in & zsup;
    end
  end

  always_comb begin
    kill_pop = 4'd0;
    for (int i = 0; i < NUM_CH; i++) kill_pop = kill_pop + 4'(kill_vec[i]);
    kill_sum = {1'b0, kill_cnt_q} + (CNT_W+1)'(kill_pop);
    if (kill_cnt_clr_in)    kill_cnt_d = '0;
    else if (kill_sum[CNT_W]) kill_cnt_d = CNT_MAX;
    else                    kill_cnt_d = kill_sum[CNT_W-1:0];
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q    <= RUN;
      sq_cnt_q   <= '0;
      wr_en_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      kill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sq_cnt_q   <= sq_cnt_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      kill_cnt_q <= kill_cnt_d;
    end
  end

  assign wr_en_out         = wr_en_q;
  assign wr_addr_out       = addr_q;
  assign wr_data_out       = data_q;
  assign squash_active_out = (state_q == SQUASH);
  assign kill_cnt_out      = kill_cnt_q;

endmodule

// File: doc/msrv32_wr_en_ctrl.md
# msrv32_wr_en_ctrl

Parametrised, registered write-enable controller for the msrv32 writeback stage. It generalises the single-cycle flush gating of the integer and CSR write enables to NUM_CH write channels. It adds a programmable post-flush squash window, stall handling, per-channel address-zero suppression and a saturating count of killed writes. It sits between the WB pipeline register and the integer and CSR register files, and drives their write ports one cycle after a request is captured.

## Interface
- NUM_CH, 2: number of write channels (ch0 = integer RF, ch1 = CSR file, further channels spare); 1..8
- ADDR_W, 12: per-channel write address width
- DATA_W, 32: per-channel write data width
- SQUASH_CYCLES, 2: accepted slots killed after a flush; 0..15 (0 = flush cycle only)
- ZERO_SUPPRESS, 2'b01: NUM_CH-bit mask; channel i drops writes to address 0 when bit i set
- CNT_W, 8: width of kill counter

Ports:
- ms_riscv32_mp_clk_in  in  1  clock, rising edge
- ms_riscv32_mp_rst_in  in  1  reset, asynchronous, active-high
- flush_in  in  1  pipeline flush (trap/branch redirect)
- stall_in  in  1  pipeline freeze; upstream holds inputs stable while high
- wr_en_req_in  in  NUM_CH  per-channel write request
- wr_addr_in  in  NUM_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
- wr_data_in  in  NUM_CH*DATA_W  packed data, same packing
- kill_cnt_clr_in  in  1  synchronous clear of kill counter
- wr_en_out  out  NUM_CH  registered write enables
- wr_addr_out  out  NUM_CH*ADDR_W  registered addresses
- wr_data_out  out  NUM_CH*DATA_W  registered data
- squash_active_out  out  1  high while squash window open (state SQUASH)
- kill_cnt_out  out  CNT_W  saturating count of killed channel writes

## Operation
- Slot: a rising edge with stall_in=0. Only slots capture requests.
- Priority per edge: reset > flush_in > stall_in > squash > normal.
- Normal (state RUN, no flush, no stall): wr_en_out[i] <= wr_en_req_in[i] & ~zsup[i], where zsup[i] = ZERO_SUPPRESS[i] & (addr_i == 0). Addr and data are loaded for all channels regardless of enable.
- flush_in=1 (any state, stall ignored): wr_en_out <= 0; addr/data load; counter sq_cnt <= SQUASH_CYCLES; state <= SQUASH if SQUASH_CYCLES>0, else RUN.
- SQUASH, slot, no flush: wr_en_out <= 0; addr/data load; sq_cnt decrements; on the slot where sq_cnt==1, state <= RUN.
- stall_in=1, no flush: wr_en_out <= 0; addr/data, sq_cnt and state hold. Each request produces at most one wr_en pulse; there are no duplicate writes across a stall.
- Kill: a channel with wr_en_req_in[i]=1 whose enable is forced 0 by flush, squash or zsup. Requests blocked only by stall are not kills (they are replayed).
- kill_cnt_out increments by popcount of kills in that edge and saturates at 2^CNT_W-1. kill_cnt_clr_in=1 loads 0 and discards same-edge kills.
- FSM: RUN -> SQUASH on flush (SQUASH_CYCLES>0). SQUASH -> SQUASH on flush (reload). SQUASH -> RUN when the last squash slot completes.

## Timing
- Reset values: wr_en_out=0, wr_addr_out=0, wr_data_out=0, kill_cnt_out=0, squash_active_out=0, state RUN, sq_cnt=0.
- Reset is asynchronous. Assertion mid-squash or mid-stall returns to RUN immediately. The first edge after deassertion is a normal edge.
- Latency: request at edge N appears on wr_en_out after edge N, valid for exactly one cycle unless re-requested.
- All outputs are registered. There is no combinational path from inputs to outputs.
- squash_active_out is high from the edge after flush until the edge completing the last squash slot.
- Flush during stall: the flush is honoured and the window starts. Squash slots count only unstalled edges.
- Simultaneous flush and kill_cnt_clr: counter clears; the flush's kills are not counted.

## Test plan
- Reset release, NUM_CH=2, req=2'b11 with addr0=5, addr1=0x300 every cycle: wr_en_out=2'b11 one cycle after each edge; addrs match; kill_cnt_out=0.
- Zero suppress: ch0 addr=0 req=1, ch1 addr=0 req=1 -> wr_en_out=2'b10; kill_cnt_out increments by 1.
- Flush with SQUASH_CYCLES=2, req=2'b11 continuously: wr_en_out=0 for 3 cycles (flush plus 2 slots); squash_active_out high for 2 cycles; kill_cnt_out +6; enables resume in the 4th cycle.
- Stall 3 cycles inside squash window: wr_en_out stays 0, squash_active_out stays high; window ends 2 unstalled slots after flush; no kills counted during stall cycles.
- Second flush during SQUASH reloads the window: total 0-enable span = 2 slots after second flush; kill_cnt saturates at 255 when preloaded to 254 with 2 kills.
- Async reset asserted mid-squash between clock edges: outputs and kill_cnt_out go 0 immediately; squash_active_out=0; first post-reset request is written.
